vga_timing_gen: RTL

Parametrised VGA raster timing generator, replacing the fixed 800x600@75 Hz counter pair. It produces hsync, vsync, video_on and active-area pixel coordinates for any mode set by parameters. Sync polarity and an integer pixel-clock prescaler are configurable, a run enable and line/frame strobes are provided, and there is an asynchronous reset. It sits between the board clock and the pong renderer and display output.

---
 rtl/vga_timing_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. A prescaler divides clk down to
// the pixel rate; horizontal and vertical counters walk the raster in the
// order display, front porch, sync, back porch. Every output is a register
// loaded from the *next* counter values on the tick edge, so the outputs
// always describe the current raster position with no extra latency.
//
// Optional feature macro: VGA_FRAME_COUNT_EN
//   defined   -> 16-bit wrapping frame_count output is present
//   undefined -> no frame_count port or register
//
// Ports:
//   clk          system clock (single domain)
//   reset        asynchronous active-high reset
//   enable       run enable; low freezes prescaler, counters and outputs
//   pix_tick     one-clk pulse per pixel period
//   hsync        horizontal sync, active level HSYNC_POL
//   vsync        vertical sync, active level VSYNC_POL
//   video_on     high inside the active area
//   pixel_x/y    active-area coordinates, 0 outside the active area
//   line_start   one-clk pulse when h_cnt becomes 0
//   frame_start  one-clk pulse when (h_cnt, v_cnt) becomes (0, 0)
//   frame_count  frames started, wrapping (VGA_FRAME_COUNT_EN only)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_DISPLAY = 800,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 80,
    parameter int H_BACK    = 160,
    parameter int V_DISPLAY = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 3,
    parameter int V_BACK    = 21,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int CLK_DIV   = 1,
    parameter int CW        = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          pix_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0]   frame_count
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_DISP_C   = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_DISP_C   = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // Prescaler width; a one-bit counter that never leaves 0 covers CLK_DIV=1.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;
    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;

    logic          w_tick;
    logic          w_h_last;
    logic          w_v_last;
    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic          w_video_next;
    logic          w_hs_active;
    logic          w_vs_active;

    assign w_tick   = enable && (r_div_cnt == DIV_LAST);
    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    // Position after the pending tick; outputs are decoded from these so they
    // land on the same edge as the counter advance.
    assign w_h_next = w_h_last ? '0 : r_h_cnt + 1'b1;
    assign w_v_next = !w_h_last ? r_v_cnt : (w_v_last ? '0 : r_v_cnt + 1'b1);

    assign w_video_next = (w_h_next < H_DISP_C) && (w_v_next < V_DISP_C);
    assign w_hs_active  = (w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST);
    assign w_vs_active  = (w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Parked on the last position so the first tick enters (0,0).
            r_div_cnt   <= '0;
            r_h_cnt     <= H_LAST;
            r_v_cnt     <= V_LAST;
            pix_tick    <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
`ifdef VGA_FRAME_COUNT_EN
            frame_count <= '0;
`endif
        end else begin
            pix_tick    <= w_tick;
            line_start  <= 1'b0;
            frame_start <= 1'b0;

            // With enable low the prescaler holds mid-pixel and resumes later.
            if (enable) begin
                r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            end

            if (w_tick) begin
                r_h_cnt     <= w_h_next;
                r_v_cnt     <= w_v_next;
                video_on    <= w_video_next;
                pixel_x     <= w_video_next ? w_h_next : '0;
                pixel_y     <= w_video_next ? w_v_next : '0;
                hsync       <= w_hs_active ? HSYNC_POL : ~HSYNC_POL;
                vsync       <= w_vs_active ? VSYNC_POL : ~VSYNC_POL;
                line_start  <= w_h_last;
                frame_start <= w_h_last && w_v_last;
`ifdef VGA_FRAME_COUNT_EN
                if (w_h_last && w_v_last) begin
                    frame_count <= frame_count + 16'd1;
                end
`endif
            end
        end
    end

endmodule
